// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/busy/done request and result bundle for seq_alu
interface seq_alu_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
);
    logic              start;
    logic [AWIDTH-1:0] aluop;
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [DWIDTH-1:0] result;
    logic              zero;
    logic              busy;
    logic              done;

    modport master (
        output start, aluop, a, b,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, aluop, a, b,
        output result, zero, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle execute ALU, one-bit-per-cycle shifts
// SEQ_ALU_BARREL_EN: compute shifts combinationally in EXEC (fixed 2-cycle latency)
module seq_alu #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4,
    parameter int SWIDTH = 5
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam logic [AWIDTH-1:0] ALUADD  = AWIDTH'(0);
    localparam logic [AWIDTH-1:0] ALUSUB  = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ALUAND  = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] ALUOR   = AWIDTH'(3);
    localparam logic [AWIDTH-1:0] ALUXOR  = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] ALUSLL  = AWIDTH'(5);
    localparam logic [AWIDTH-1:0] ALUSRL  = AWIDTH'(6);
    localparam logic [AWIDTH-1:0] ALUSRA  = AWIDTH'(7);
    localparam logic [AWIDTH-1:0] ALUSLT  = AWIDTH'(8);
    localparam logic [AWIDTH-1:0] ALUSLTU = AWIDTH'(9);

`ifdef SEQ_ALU_BARREL_EN
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;
`endif

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] op_q, op_d;
    logic [DWIDTH-1:0] a_q, a_d;
    logic [DWIDTH-1:0] b_q, b_d;
    logic [DWIDTH-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic [DWIDTH-1:0] alu_val;
`ifndef SEQ_ALU_BARREL_EN
    logic [DWIDTH-1:0] work_q, work_d;
    logic [SWIDTH-1:0] cnt_q, cnt_d;
`endif

    // Unlisted codes, and shifts in the iterative build, fall through to ADD
    always_comb begin
        alu_val = a_q + b_q;
        case (op_q)
            ALUSUB:  alu_val = a_q - b_q;
            ALUAND:  alu_val = a_q & b_q;
            ALUOR:   alu_val = a_q | b_q;
            ALUXOR:  alu_val = a_q ^ b_q;
            ALUSLT:  alu_val = {{(DWIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALUSLTU: alu_val = {{(DWIDTH-1){1'b0}}, a_q < b_q};
`ifdef SEQ_ALU_BARREL_EN
            ALUSLL:  alu_val = a_q << b_q[SWIDTH-1:0];
            ALUSRL:  alu_val = a_q >> b_q[SWIDTH-1:0];
            ALUSRA:  alu_val = $unsigned($signed(a_q) >>> b_q[SWIDTH-1:0]);
`endif
            default: alu_val = a_q + b_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifndef SEQ_ALU_BARREL_EN
        work_d   = work_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.aluop;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
`ifndef SEQ_ALU_BARREL_EN
                if (op_q == ALUSLL || op_q == ALUSRL || op_q == ALUSRA) begin
                    work_d  = a_q;
                    cnt_d   = b_q[SWIDTH-1:0];
                    state_d = SHIFT;
                end else
`endif
                begin
                    result_d = alu_val;
                    zero_d   = (alu_val == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
`ifndef SEQ_ALU_BARREL_EN
            SHIFT: begin
                if (cnt_q == '0) begin
                    result_d = work_q;
                    zero_d   = (work_q == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - SWIDTH'(1);
                    case (op_q)
                        ALUSLL:  work_d = {work_q[DWIDTH-2:0], 1'b0};
                        ALUSRL:  work_d = {1'b0, work_q[DWIDTH-1:1]};
                        default: work_d = {work_q[DWIDTH-1], work_q[DWIDTH-1:1]};
                    endcase
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifndef SEQ_ALU_BARREL_EN
            work_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifndef SEQ_ALU_BARREL_EN
            work_q   <= work_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed scoreboard bench for seq_alu (honours SEQ_ALU_BARREL_EN)
module tb_seq_alu;
    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] AND_ = 4'd2;
    localparam logic [3:0] OR_  = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4;
    localparam logic [3:0] SLL  = 4'd5;
    localparam logic [3:0] SRL  = 4'd6;
    localparam logic [3:0] SRA  = 4'd7;
    localparam logic [3:0] SLT  = 4'd8;
    localparam logic [3:0] SLTU = 4'd9;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.DWIDTH(32), .AWIDTH(4)) bus ();

    seq_alu #(.DWIDTH(32), .AWIDTH(4), .SWIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   accepted = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [3:0] op, input logic [31:0] b);
`ifdef SEQ_ALU_BARREL_EN
        return 2;
`else
        if (op == SLL || op == SRL || op == SRA) return 3 + int'(b[4:0]);
        return 2;
`endif
    endfunction

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy && bus.done) check("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
            if (bus.done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.result, e.res);
                    check("zero", 32'(bus.zero), 32'(e.z));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res);
        exp_t e;
        bus.start = 1'b1;
        bus.aluop = op;
        bus.a     = a;
        bus.b     = b;
        e.res = res;
        e.z   = (res == 32'd0);
        e.cyc = cyc + lat(op, b);
        sb.push_back(e);
        accepted++;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res);
        wait_idle();
        drive(op, a, b, res);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        int n;
        int t;
        bus.start = 1'b0;
        bus.aluop = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_result", bus.result, 32'd0);
        check("reset_zero", 32'(bus.zero), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);

        issue(ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        issue(SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
        issue(SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
        issue(SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
        issue(4'hF, 32'd3,         32'd4,         32'd7);
        issue(AND_, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        issue(OR_,  32'h0000_0F0F, 32'h0000_F000, 32'h0000_FF0F);
        issue(SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);
        issue(SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
        issue(SRL,  32'h0000_0080, 32'h0000_0023, 32'h0000_0010);
        issue(SLL,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234);

        // start held with changing operands while busy, then restart in the done cycle
        wait_idle();
        drive(SLL, 32'd1, 32'd4, 32'h0000_0010);
        n = lat(SLL, 32'd4);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            bus.aluop = ADD;
            bus.a     = 32'(100 + i);
            bus.b     = 32'd200;
        end
        @(negedge clk);
        check("busy_in_done_cycle", 32'(bus.busy), 32'd0);
        drive(XOR_, 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_0F0F);
        @(negedge clk);
        bus.start = 1'b0;

        // reset while shifting abandons the op
        issue(SLL, 32'd1, 32'd20, 32'h0010_0000);
`ifndef SEQ_ALU_BARREL_EN
        repeat (2) @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        check("rst_mid_result", bus.result, 32'd0);
        check("rst_mid_zero", 32'(bus.zero), 32'd1);
        void'(sb.pop_back());
        accepted--;
        rst = 1'b0;
        repeat (40) @(negedge clk);

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(accepted));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
